hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. Detects load-use hazards and taken-branch redirects, and sequences a fixed-latency multi-cycle mul/div unit in EX and data-memory wait states in MEM. It produces per-stage write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sits beside the forwarding unit; anything forwarding cannot resolve is stalled here.

---
 rtl/hazard_ctrl_pkg.sv | 8 +
 rtl/hazard_ctrl.sv | 78 +++++++
 tb/tb_hazard_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encodings for the pipeline sequencing controller
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for load-use, branches, mul/div and dmem waits
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic [4:0] EX_rd,
  input  logic       EX_memread,
  input  logic       EX_muldiv,
  input  logic       EX_branch_taken,
  input  logic       MEM_memaccess,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       ID_EX_write,
  output logic       EX_MEM_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush,
  output logic       MEM_WB_flush,
  output logic       md_start,
  output logic       busy
);
  localparam int CW = $clog2(MD_LATENCY);
  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_md_cnt, w_md_cnt_nxt;
  logic          w_dmem_wait, w_md_go, w_load_use;
  logic          w_ws, w_ms, w_ls, w_bf;
  assign w_dmem_wait = MEM_memaccess && !dmem_ready;
  assign w_md_go     = r_state == RUN && EX_muldiv;
  assign w_load_use  = EX_memread && EX_rd != 5'd0 &&
                       ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
  // Stall classes, mutually exclusive and already resolved by priority
  assign w_ws = !rst && w_dmem_wait;
  assign w_ms = !rst && !w_dmem_wait && (w_md_go || r_state == MD_BUSY);
  assign w_ls = !rst && !w_dmem_wait && !w_md_go && r_state == RUN && w_load_use && !EX_branch_taken;
  assign w_bf = !rst && !w_dmem_wait && r_state != MD_BUSY && !w_md_go && EX_branch_taken;
  assign pc_write     = rst || !(w_ws || w_ms || w_ls);
  assign IF_ID_write  = pc_write;
  assign ID_EX_write  = rst || !(w_ws || w_ms);
  assign EX_MEM_write = rst || !w_ws;
  assign IF_ID_flush  = rst || w_bf;
  assign ID_EX_flush  = rst || w_bf || w_ls;
  assign EX_MEM_flush = rst || w_ms;
  assign MEM_WB_flush = rst || w_ws;
  assign md_start     = !rst && !w_dmem_wait && w_md_go;
  assign busy         = w_ws || w_ms || w_ls;
  // Next state; the counter tracks the free-running unit even during dmem waits and parks at 0
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    if (r_state == MD_BUSY) begin
      w_md_cnt_nxt = (r_md_cnt == '0) ? r_md_cnt : r_md_cnt - 1'b1;
      w_state_nxt  = (!w_dmem_wait && r_md_cnt <= CW'(1)) ? MD_DONE : MD_BUSY;
    end else if (!w_dmem_wait && w_md_go) begin
      w_state_nxt  = MD_BUSY;
      w_md_cnt_nxt = CW'(MD_LATENCY - 1);
    end else if (!w_dmem_wait && r_state == MD_DONE) begin
      w_state_nxt  = RUN;
    end
  end
  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized check of hazard_ctrl against a cycle-level behavioural model
module tb_hazard_ctrl;
  localparam int L = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic ID_uses_rs1 = 0, ID_uses_rs2 = 0, EX_memread = 0, EX_muldiv = 0;
  logic EX_branch_taken = 0, MEM_memaccess = 0, dmem_ready = 1;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_start, busy;
  int n_vec = 0, n_err = 0;
  int phase = 0, elapsed = 0;
  logic [9:0] exp_v;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_memread(EX_memread), .EX_muldiv(EX_muldiv),
    .EX_branch_taken(EX_branch_taken), .MEM_memaccess(MEM_memaccess), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush), .md_start(md_start), .busy(busy)
  );

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (pc,ifid,idex,exmem wr | ifid,idex,exmem,memwb fl | start,busy)",
               tag, got, exp);
    end
  endtask

  // Expected controls, from the priority rules: phase 0=run, 1=mul/div in flight, 2=result ready
  function automatic logic [9:0] model();
    logic wt, lu, br;
    wt = MEM_memaccess && !dmem_ready;
    lu = EX_memread && EX_rd != 0 && ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
    br = EX_branch_taken;
    if (rst) return 10'b1111_1111_00;
    if (wt) return 10'b0000_0001_01;
    if (phase == 1) return 10'b0001_0010_01;
    if (phase == 0 && EX_muldiv) return 10'b0001_0010_11;
    if (br) return 10'b1111_1100_00;
    if (phase == 0 && lu) return 10'b0011_0100_01;
    return 10'b1111_0000_00;
  endfunction

  // Advance the model one clock; the unit's elapsed time keeps counting through waits
  task automatic step_model();
    logic wt;
    wt = MEM_memaccess && !dmem_ready;
    if (rst) begin
      phase = 0;
      elapsed = 0;
    end else if (phase == 1) begin
      if (!wt && elapsed >= L - 1) phase = 2;
      elapsed++;
    end else if (!wt && phase == 0 && EX_muldiv) begin
      phase = 1;
      elapsed = 1;
    end else if (!wt && phase == 2) begin
      phase = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst             = (i < 2) || ($urandom_range(0, 99) < 2);
      ID_rs1          = 5'($urandom_range(0, 3));
      ID_rs2          = 5'($urandom_range(0, 3));
      EX_rd           = 5'($urandom_range(0, 3));
      ID_uses_rs1     = $urandom_range(0, 3) != 0;
      ID_uses_rs2     = $urandom_range(0, 1) != 0;
      EX_memread      = $urandom_range(0, 99) < 40;
      EX_muldiv       = $urandom_range(0, 99) < 8;
      EX_branch_taken = $urandom_range(0, 99) < 20;
      MEM_memaccess   = $urandom_range(0, 99) < 40;
      dmem_ready      = $urandom_range(0, 99) < 50;
      #1;
      exp_v = model();
      check(rst ? "reset" : phase == 1 ? "md_busy" : phase == 2 ? "md_done" : "run",
            {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, md_start, busy}, exp_v);
      @(posedge clk);
      step_model();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
